// File: rtl/module_frame_receiver.sv
// Reassembles 2-byte UART command frames, validates and stages them, and
// commits the staged sine index on the rising edge of the shoot strobe.
module module_frame_receiver #(
  parameter logic [3:0]  MODULE_ID      = 4'd1,
  parameter int unsigned TIMEOUT_CYCLES = 4800,
  parameter int unsigned CNT_W          = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  data_received,
  input  logic        parity_error,
  input  logic        shoot,
  output logic [11:0] sin_index,
  output logic        module_sel,
  output logic        sin_index_valid,
  output logic        pending,
  output logic        frame_error,
  output logic        overrun,
  output logic        missed_shoot,
  output logic [7:0]  err_count
);

  localparam logic [0:0]       WAIT_HI  = 1'b0;
  localparam logic [0:0]       WAIT_LO  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       hi_byte, hi_byte_n;
  logic [11:0]      staged_index, staged_index_n;
  logic             staged_sel, staged_sel_n;
  logic             shoot_d;
  logic             shoot_edge, commit;

  logic [11:0] sin_index_n;
  logic        module_sel_n, sin_index_valid_n, pending_n;
  logic        frame_error_n, overrun_n, missed_shoot_n;
  logic [7:0]  err_count_n;

  assign shoot_edge = shoot & ~shoot_d;
  assign commit     = shoot_edge & pending;

  // Next-state, staging and commit logic; commit always sees the old staging.
  always_comb begin
    state_n           = state;
    cnt_n             = cnt;
    hi_byte_n         = hi_byte;
    staged_index_n    = staged_index;
    staged_sel_n      = staged_sel;
    pending_n         = pending;
    sin_index_n       = sin_index;
    module_sel_n      = module_sel;
    sin_index_valid_n = 1'b0;
    frame_error_n     = 1'b0;
    overrun_n         = 1'b0;
    missed_shoot_n    = 1'b0;

    if (commit) begin
      sin_index_n       = staged_index;
      module_sel_n      = staged_sel;
      sin_index_valid_n = 1'b1;
      pending_n         = 1'b0;
    end else if (shoot_edge) begin
      missed_shoot_n = 1'b1;
    end

    case (state)
      WAIT_LO: begin
        if (rx_done) begin
          state_n = WAIT_HI;
          if (parity_error) begin
            frame_error_n = 1'b1;
            hi_byte_n     = 8'h00;
          end else begin
            staged_index_n = {hi_byte, data_received[7:4]};
            staged_sel_n   = (data_received[3:0] == MODULE_ID);
            pending_n      = 1'b1;
            overrun_n      = pending & ~commit;
          end
        end else if (cnt == CNT_LAST) begin
          frame_error_n = 1'b1;
          state_n       = WAIT_HI;
          cnt_n         = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (rx_done) begin
          if (parity_error) begin
            frame_error_n = 1'b1;
          end else begin
            hi_byte_n = data_received;
            cnt_n     = '0;
            state_n   = WAIT_LO;
          end
        end
      end
    endcase

    err_count_n = (frame_error_n && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
  end

  // Shoot history resets high so a strobe held across reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_HI;
      cnt             <= '0;
      hi_byte         <= 8'h00;
      staged_index    <= 12'h000;
      staged_sel      <= 1'b0;
      shoot_d         <= 1'b1;
      sin_index       <= 12'h000;
      module_sel      <= 1'b0;
      sin_index_valid <= 1'b0;
      pending         <= 1'b0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
      missed_shoot    <= 1'b0;
      err_count       <= 8'h00;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      hi_byte         <= hi_byte_n;
      staged_index    <= staged_index_n;
      staged_sel      <= staged_sel_n;
      shoot_d         <= shoot;
      sin_index       <= sin_index_n;
      module_sel      <= module_sel_n;
      sin_index_valid <= sin_index_valid_n;
      pending         <= pending_n;
      frame_error     <= frame_error_n;
      overrun         <= overrun_n;
      missed_shoot    <= missed_shoot_n;
      err_count       <= err_count_n;
    end
  end

endmodule

// File: tb/tb_module_frame_receiver.sv
// Directed bench for module_frame_receiver: framing, timeout, parity,
// overrun, commit timing, simultaneous events, reset and error saturation.
module tb_module_frame_receiver;

  localparam int unsigned TO = 40;

  logic        clk;
  logic        reset;
  logic        rx_done;
  logic [7:0]  data_received;
  logic        parity_error;
  logic        shoot;
  logic [11:0] sin_index;
  logic        module_sel;
  logic        sin_index_valid;
  logic        pending;
  logic        frame_error;
  logic        overrun;
  logic        missed_shoot;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0, err_cnt = 0, missed_cnt = 0;
  int v0, m0, e0;

  module_frame_receiver #(
    .MODULE_ID(4'd3),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_done(rx_done),
    .data_received(data_received),
    .parity_error(parity_error),
    .shoot(shoot),
    .sin_index(sin_index),
    .module_sel(module_sel),
    .sin_index_valid(sin_index_valid),
    .pending(pending),
    .frame_error(frame_error),
    .overrun(overrun),
    .missed_shoot(missed_shoot),
    .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (sin_index_valid) valid_cnt <= valid_cnt + 1;
    if (frame_error)     err_cnt   <= err_cnt + 1;
    if (missed_shoot)    missed_cnt <= missed_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b, input logic par);
    rx_done = 1'b1; data_received = b; parity_error = par;
    @(negedge clk);
    rx_done = 1'b0; data_received = 8'h00; parity_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic commit_check(input string tag, input logic [11:0] idx, input logic sel);
    shoot = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, 32'(sin_index_valid), 32'd1);
    check({tag, "_idx"}, 32'(sin_index), 32'(idx));
    check({tag, "_sel"}, 32'(module_sel), 32'(sel));
    check({tag, "_pend"}, 32'(pending), 32'd0);
    shoot = 1'b0;
    @(negedge clk);
    check({tag, "_valid_off"}, 32'(sin_index_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; data_received = 8'h00; parity_error = 1'b0; shoot = 1'b0;
    idle(3);
    check("rst_idx", 32'(sin_index), 32'd0);
    check("rst_sel", 32'(module_sel), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    reset = 1'b0;
    idle(1);

    // Matching id frame
    send_byte(8'hAB, 1'b0);
    check("t1_pend_hi", 32'(pending), 32'd0);
    send_byte(8'hC3, 1'b0);
    check("t1_pend_lo", 32'(pending), 32'd1);
    commit_check("t1", 12'hABC, 1'b1);
    idle(2);
    check("t1_hold", 32'(sin_index), 32'hABC);

    // Foreign id is valid, not an error
    send_byte(8'h12, 1'b0);
    send_byte(8'h45, 1'b0);
    commit_check("t2", 12'h124, 1'b0);
    idle(1);
    check("t2_no_err", 32'(err_cnt), 32'd0);

    // Timeout: no error one cycle before expiry, error at expiry
    send_byte(8'hAB, 1'b0);
    idle(TO - 1);
    check("t3_pre_to", 32'(frame_error), 32'd0);
    idle(1);
    check("t3_to", 32'(frame_error), 32'd1);
    check("t3_errcnt", 32'(err_count), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    commit_check("t3", 12'h012, 1'b1);

    // Byte 2 landing on the expiry cycle wins over the timeout
    send_byte(8'h77, 1'b0);
    idle(TO - 1);
    send_byte(8'h83, 1'b0);
    check("t3b_no_err", 32'(frame_error), 32'd0);
    check("t3b_pend", 32'(pending), 32'd1);
    idle(2);
    check("t3b_errcnt", 32'(err_count), 32'd1);
    commit_check("t3b", 12'h778, 1'b1);

    // Parity error on byte 1
    send_byte(8'hFF, 1'b1);
    check("t4_ferr", 32'(frame_error), 32'd1);
    check("t4_errcnt", 32'(err_count), 32'd2);
    send_byte(8'h55, 1'b0);
    send_byte(8'h63, 1'b0);
    commit_check("t4", 12'h556, 1'b1);

    // Overrun
    send_byte(8'h10, 1'b0);
    send_byte(8'h03, 1'b0);
    check("t5_no_ovr", 32'(overrun), 32'd0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h03, 1'b0);
    check("t5_ovr", 32'(overrun), 32'd1);
    commit_check("t5", 12'h200, 1'b1);

    // Frame completes with shoot edge while nothing pending
    send_byte(8'h9A, 1'b0);
    rx_done = 1'b1; data_received = 8'hB3; shoot = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; data_received = 8'h00;
    check("t6a_missed", 32'(missed_shoot), 32'd1);
    check("t6a_valid", 32'(sin_index_valid), 32'd0);
    check("t6a_pend", 32'(pending), 32'd1);
    check("t6a_idx", 32'(sin_index), 32'h200);
    shoot = 1'b0;
    @(negedge clk);
    commit_check("t6a", 12'h9AB, 1'b1);

    // Frame completes with shoot edge while an older frame is pending
    send_byte(8'h44, 1'b0);
    send_byte(8'h53, 1'b0);
    send_byte(8'h66, 1'b0);
    rx_done = 1'b1; data_received = 8'h70; shoot = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; data_received = 8'h00;
    check("t6b_valid", 32'(sin_index_valid), 32'd1);
    check("t6b_idx", 32'(sin_index), 32'h445);
    check("t6b_sel", 32'(module_sel), 32'd1);
    check("t6b_pend", 32'(pending), 32'd1);
    check("t6b_ovr", 32'(overrun), 32'd0);
    shoot = 1'b0;
    @(negedge clk);
    commit_check("t6b", 12'h667, 1'b0);

    // Missed shoot, then reset mid-frame with shoot held high
    shoot = 1'b1;
    @(negedge clk);
    check("t7_missed", 32'(missed_shoot), 32'd1);
    check("t7_valid", 32'(sin_index_valid), 32'd0);
    shoot = 1'b0;
    idle(1);
    send_byte(8'h31, 1'b0);
    shoot = 1'b1; reset = 1'b1;
    idle(2);
    check("t7_rst_idx", 32'(sin_index), 32'd0);
    check("t7_rst_sel", 32'(module_sel), 32'd0);
    check("t7_rst_pend", 32'(pending), 32'd0);
    check("t7_rst_errcnt", 32'(err_count), 32'd0);
    check("t7_rst_valid", 32'(sin_index_valid), 32'd0);
    check("t7_rst_missed", 32'(missed_shoot), 32'd0);
    v0 = valid_cnt; m0 = missed_cnt;
    reset = 1'b0;
    idle(4);
    check("t7_no_false_commit", 32'(valid_cnt), 32'(v0));
    check("t7_no_false_missed", 32'(missed_cnt), 32'(m0));
    send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0);
    check("t7_pend", 32'(pending), 32'd1);
    shoot = 1'b0;
    @(negedge clk);
    commit_check("t7", 12'h234, 1'b0);

    // Error counter saturation
    e0 = err_cnt;
    repeat (300) send_byte(8'h00, 1'b1);
    check("sat_ferr", 32'(frame_error), 32'd1);
    check("sat_errcnt", 32'(err_count), 32'hFF);
    idle(2);
    check("sat_pulses", 32'(err_cnt - e0), 32'd300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/module_frame_receiver.md
Name: module_frame_receiver

Overview:
- Runs on each power-module FPGA, directly downstream of the main FPGA's per-module UART link.
- Consumes bytes from a `uart_rx` instance and reassembles the 2-byte command frame: byte 1 = sin_index[11:4], byte 2 = {sin_index[3:0], uart_id}.
- Validates each frame and stages it. Applies the staged value to the gate-control logic only on the rising edge of the shoot pulse, so all modules switch simultaneously.

Parameters:
- MODULE_ID, 4'd1, this module's 4-bit id; compared against the uart_id field of each frame.
- TIMEOUT_CYCLES, 4800, max clk cycles allowed between byte 1 and byte 2 before the partial frame is discarded.
- CNT_W, 13, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; the same clock that drives uart_rx.
- reset  input  1  synchronous, active-high.
- rx_done  input  1  single-cycle pulse; a byte is present on data_received.
- data_received  input  8  received byte; valid only while rx_done=1.
- parity_error  input  1  parity flag for the byte; valid only while rx_done=1.
- shoot  input  1  commit strobe, already synchronised to clk; the rising edge commits.
- sin_index  output  12  committed sine index.
- module_sel  output  1  committed flag; 1 when the committed frame's uart_id equals MODULE_ID.
- sin_index_valid  output  1  one-cycle pulse when sin_index/module_sel update.
- pending  output  1  a validated frame is staged and not yet committed.
- frame_error  output  1  one-cycle pulse on parity error or inter-byte timeout.
- overrun  output  1  one-cycle pulse when a new frame overwrites an uncommitted staged frame.
- missed_shoot  output  1  one-cycle pulse when a shoot edge arrives with pending=0.
- err_count  output  8  saturating count of frame_error pulses.

Behaviour:
- Reset:
  - All outputs 0, state WAIT_HI, timeout counter 0, staging registers 0.
  - The shoot edge-detect register is set to 1, so a shoot held high across reset does not produce a false edge.
  - Reset mid-frame discards the partial byte.
- FSM states: WAIT_HI, WAIT_LO.
- WAIT_HI:
  - rx_done & parity_error: pulse frame_error, stay in WAIT_HI.
  - rx_done & !parity_error: latch hi_byte <= data_received, clear counter, go to WAIT_LO.
- WAIT_LO:
  - The counter increments every cycle without rx_done.
  - rx_done & !parity_error:
    - staged_index <= {hi_byte, data_received[7:4]}.
    - staged_sel <= (data_received[3:0] == MODULE_ID).
    - pending <= 1.
    - If pending was already 1 and no commit occurs in this cycle, pulse overrun.
    - Go to WAIT_HI.
  - rx_done & parity_error: pulse frame_error, discard hi_byte, go to WAIT_HI.
  - Counter reaches TIMEOUT_CYCLES-1 with no rx_done: pulse frame_error, go to WAIT_HI.
  - If rx_done and timeout expiry fall in the same cycle, rx_done wins and no error is raised.
- Commit:
  - Edge detect: shoot_edge = shoot & !shoot_d.
  - shoot_edge with pending=1: on the next edge, sin_index <= staged_index, module_sel <= staged_sel, sin_index_valid=1 for one cycle, pending <= 0.
  - Latency is one cycle from the cycle shoot is first sampled high.
  - shoot_edge with pending=0: outputs hold, pulse missed_shoot.
- Simultaneous frame completion and shoot_edge:
  - The commit uses the previously staged value.
  - The new frame then overwrites staging and pending stays 1.
  - No overrun pulse is raised.
  - If pending was 0 beforehand, missed_shoot pulses and the new frame remains pending.
- err_count increments on each frame_error pulse and saturates at 8'hFF.
- Outputs other than the pulses hold their value indefinitely between commits.
- A uart_id not matching MODULE_ID is a valid frame, not an error; it commits with module_sel=0.

Test Plan:
- MODULE_ID=3. Send 0xAB, then 0xC3, then a shoot edge. Required: pending=1 after the second byte; one cycle after the edge, sin_index=0xABC, module_sel=1, sin_index_valid high for exactly one cycle; pending=0.
- Send 0x12, then 0x45 (id=5 ≠ 3), then shoot. Required: sin_index=0x124, module_sel=0, frame_error never asserted.
- Send 0xAB, then nothing for TIMEOUT_CYCLES. Required: frame_error pulse, err_count=1. Then 0x01, 0x23, shoot gives sin_index=0x012, proving 0x01 was treated as a high byte.
- Send byte 1 with parity_error=1, then 0x55, 0x63, shoot. Required: one frame_error; sin_index=0x556, module_sel=1.
- Send two complete frames 0x10,0x03 and 0x20,0x03 with no shoot between, then shoot. Required: overrun pulse on the second frame; sin_index=0x200.
- With pending=0: shoot edge gives missed_shoot and no sin_index_valid. Then assert reset between byte 1 and byte 2 with shoot held high. Required: all outputs 0; no false commit after reset deasserts.
